valid_delay_pipe: RTL and testbench

Parametrised elastic delay line: carries a WID-bit payload with a valid bit through DEP register stages. It adds downstream backpressure, bubble collapsing, synchronous flush and occupancy reporting to the plain fixed-latency delay stages. It is used wherever a datapath needs a pipeline-matched delay that can also stall, such as operand or tag tracking alongside multi-cycle functional units.

---
 rtl/valid_delay_pipe_if.sv | 23 ++
 rtl/valid_delay_pipe.sv | 96 +++++++++
 tb/tb_valid_delay_pipe.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/valid_delay_pipe_if.sv
// Handshake/payload bundle for valid_delay_pipe.
// The master is the environment: it drives the upstream payload and the
// downstream ready. The slave is the pipe itself.
interface valid_delay_pipe_if #(
    parameter int unsigned WID = 32
);
    logic           i_valid;
    logic [WID-1:0] i_data;
    logic           i_ready;
    logic           o_valid;
    logic [WID-1:0] o_data;
    logic           o_ready;

    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data
    );

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data
    );
endinterface

// File: rtl/valid_delay_pipe.sv
// Elastic DEP-stage delay line.
// Each stage holds a valid bit and a payload. Stages collapse bubbles: an
// empty stage always loads, even when the stage downstream is stalled.
// The ld/mv chain runs combinationally from o_ready back to i_ready.
module valid_delay_pipe #(
    parameter int unsigned WID = 32,
    parameter int unsigned DEP = 4,
    localparam int unsigned CW = $clog2(DEP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             flush,
    valid_delay_pipe_if.slave bus,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [DEP-1:0] v_q;
    logic [DEP-1:0] v_d;
    logic [WID-1:0] d_q [DEP];
    logic [WID-1:0] d_d [DEP];
    logic [DEP-1:0] ld;
    logic [DEP-1:0] mv;
    logic [CW-1:0]  count_c;

    // Load/move enables, evaluated from the output stage back to stage 0.
    always_comb begin
        mv = '0;
        ld = '0;
        mv[DEP-1] = ce & v_q[DEP-1] & bus.o_ready & ~flush;
        ld[DEP-1] = ce & ~flush & (~v_q[DEP-1] | mv[DEP-1]);
        for (int unsigned j = 1; j < DEP; j++) begin
            mv[DEP-1-j] = v_q[DEP-1-j] & ld[DEP-j];
            ld[DEP-1-j] = ce & ~flush & (~v_q[DEP-1-j] | mv[DEP-1-j]);
        end
    end

    // Next stage state: flush clears valids only; payload loads only with a valid.
    always_comb begin
        v_d = v_q;
        for (int unsigned k = 0; k < DEP; k++) begin
            d_d[k] = d_q[k];
        end
        if (flush) begin
            v_d = '0;
        end else begin
            if (ld[0]) begin
                v_d[0] = bus.i_valid;
                if (bus.i_valid) begin
                    d_d[0] = bus.i_data;
                end
            end
            for (int unsigned k = 1; k < DEP; k++) begin
                if (ld[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        d_d[k] = d_q[k-1];
                    end
                end
            end
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int unsigned k = 0; k < DEP; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int unsigned k = 0; k < DEP; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    // Occupancy: popcount of the stage valid bits.
    always_comb begin
        count_c = '0;
        for (int unsigned k = 0; k < DEP; k++) begin
            count_c = count_c + CW'(v_q[k]);
        end
    end

    assign count       = count_c;
    assign full        = (count_c == CW'(DEP));
    assign empty       = (count_c == '0);
    assign bus.i_ready = ld[0];
    assign bus.o_valid = v_q[DEP-1];
    assign bus.o_data  = d_q[DEP-1];

endmodule

// File: tb/tb_valid_delay_pipe.sv
// Scoreboard bench for valid_delay_pipe (DEP=4, WID=32).
// Directed tests push their hand-computed output sequence into a queue;
// a negedge monitor pops and compares on every output transfer.
module tb_valid_delay_pipe;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       flush;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] sb [$];

    valid_delay_pipe_if #(.WID(32)) bus ();

    valid_delay_pipe #(.WID(32), .DEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .flush (flush),
        .bus   (bus),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: one pop per output transfer.
    always @(negedge clk) begin
        if (rst_n && ce && !flush && bus.o_valid && bus.o_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %h expected none", bus.o_data);
            end else begin
                chk("out_data", bus.o_data, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] val);
        int n;
        n = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = val;
        #1;
        while (!bus.i_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        step();
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.o_ready = 1'b1;
        #1;
        while (!empty && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; flush = 1'b0;
        bus.i_valid = 1'b0; bus.i_data = '0; bus.o_ready = 1'b1;
        #12;
        // Reset state
        chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_o_data", bus.o_data, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_i_ready", 32'(bus.i_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Latency / streaming: 1..8 back to back
        for (int i = 1; i <= 8; i++) sb.push_back(32'(i));
        for (int i = 1; i <= 8; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = 32'(i);
            #1;
            chk("stream_i_ready", 32'(bus.i_ready), 32'd1);
            step();
            chk("lat_o_valid", 32'(bus.o_valid), (i >= 4) ? 32'd1 : 32'd0);
            if (i >= 4) chk("stream_count", 32'(count), 32'd4);
            if (i == 4) chk("lat_first_data", bus.o_data, 32'd1);
        end
        bus.i_valid = 1'b0;
        drain();

        // Backpressure fill
        bus.o_ready = 1'b0;
        for (int j = 0; j < 6; j++) sb.push_back(32'hA0 + 32'(j));
        for (int j = 0; j < 4; j++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = 32'hA0 + 32'(j);
            #1;
            chk("bp_i_ready_fill", 32'(bus.i_ready), 32'd1);
            step();
        end
        bus.i_data = 32'hA4;
        #1;
        chk("bp_i_ready_full", 32'(bus.i_ready), 32'd0);
        chk("bp_full", 32'(full), 32'd1);
        chk("bp_count", 32'(count), 32'd4);
        step();
        chk("bp_hold_o_data", bus.o_data, 32'hA0);
        bus.o_ready = 1'b1;
        #1;
        chk("bp_release_i_ready", 32'(bus.i_ready), 32'd1);
        step();
        chk("bp_count_same", 32'(count), 32'd4);
        send(32'hA5);
        drain();

        // Bubble collapse
        bus.o_ready = 1'b0;
        sb.push_back(32'h11);
        sb.push_back(32'h22);
        send(32'h11);
        step();
        step();
        send(32'h22);
        for (int i = 0; i < 4; i++) step();
        chk("bub_count", 32'(count), 32'd2);
        chk("bub_o_data", bus.o_data, 32'h11);
        bus.o_ready = 1'b1;
        step();
        chk("bub_b2b_valid", 32'(bus.o_valid), 32'd1);
        chk("bub_b2b_data", bus.o_data, 32'h22);
        step();
        chk("bub_empty", 32'(empty), 32'd1);
        drain();

        // ce gating
        bus.o_ready = 1'b0;
        for (int j = 1; j <= 4; j++) sb.push_back(32'h30 + 32'(j));
        send(32'h31);
        send(32'h32);
        for (int i = 0; i < 4; i++) step();
        ce = 1'b0;
        bus.o_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h33;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("ce_i_ready", 32'(bus.i_ready), 32'd0);
            chk("ce_count", 32'(count), 32'd2);
            chk("ce_o_data", bus.o_data, 32'h31);
            step();
        end
        ce = 1'b1;
        send(32'h33);
        send(32'h34);
        drain();

        // flush
        bus.o_ready = 1'b0;
        for (int j = 1; j <= 4; j++) send(32'h40 + 32'(j));
        chk("fl_full", 32'(full), 32'd1);
        flush = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h55;
        #1;
        chk("fl_i_ready", 32'(bus.i_ready), 32'd0);
        step();
        flush = 1'b0;
        bus.i_valid = 1'b0;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_o_valid", 32'(bus.o_valid), 32'd0);
        chk("fl_empty", 32'(empty), 32'd1);
        bus.o_ready = 1'b1;
        sb.push_back(32'h66);
        send(32'h66);
        drain();

        // Async reset between edges with the pipe full
        bus.o_ready = 1'b0;
        for (int j = 1; j <= 4; j++) send(32'h70 + 32'(j));
        chk("ar_full", 32'(full), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_o_valid", 32'(bus.o_valid), 32'd0);
        chk("ar_o_data", bus.o_data, 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
